// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID probe: FSM states, default
// build constants and small state-decode helpers.
package sysid_pkg;

    // Probe sequencer states, one read phase and one latency phase per word
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_ID  = 3'd1,
        S_LAT_ID = 3'd2,
        S_RD_TS  = 3'd3,
        S_LAT_TS = 3'd4,
        S_FIN    = 3'd5
    } probe_state_t;

    // Integrators override this per build with the ID their image carries
    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;

    // Register map of the system-ID slave (word addresses)
    localparam int DEFAULT_ID_ADDR = 0;
    localparam int DEFAULT_TS_ADDR = 1;

    // Read latency is bounded to 0..3, so two bits always suffice
    localparam int LAT_CNT_W = 2;

    // True while the ID word is being fetched (issue or latency phase)
    function automatic logic isIdPhase(input probe_state_t s);
        return (s == S_RD_ID) || (s == S_LAT_ID);
    endfunction

    // True while the timestamp word is being fetched
    function automatic logic isTsPhase(input probe_state_t s);
        return (s == S_RD_TS) || (s == S_LAT_TS);
    endfunction

endpackage

// File: rtl/sysid_probe_avm_single_read.sv
// Single Avalon-MM read transaction engine. A go pulse latches the
// address and raises the read strobe on the next cycle; the strobe is
// held with a stable address while the slave stalls. The engine either
// accepts the read, optionally waits a fixed latency before flagging the
// data, or gives up after TIMEOUT_CYC consecutive stall cycles.
module avm_single_read
    import sysid_pkg::*;
#(
    parameter int ADDR_W       = 1,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_go,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_waitRequest,
    input  logic [31:0]       i_readData,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_read,
    output logic              o_rdAccept,
    output logic              o_rdDone,
    output logic [31:0]       o_rdData,
    output logic              o_rdTimeout
);

    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYC);
    localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(TIMEOUT_CYC - 1);
    localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);
    localparam bit HAS_LAT = (READ_LATENCY > 0);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST =
        LAT_CNT_W'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);
    localparam logic [LAT_CNT_W-1:0] LAT_ONE = LAT_CNT_W'(1);

    logic                  r_active;
    logic                  r_latActive;
    logic [ADDR_W-1:0]     r_addr;
    logic [STALL_W-1:0]    r_stallCnt;
    logic [LAT_CNT_W-1:0]  r_latCnt;

    logic w_stalled;
    logic w_accept;
    logic w_timeout;
    logic w_latDone;

    // Decode the current cycle of the handshake from the registered strobe
    always_comb begin
        w_stalled = r_active & i_waitRequest;
        w_accept  = r_active & ~i_waitRequest;
        w_timeout = w_stalled & (r_stallCnt == STALL_LAST);
        w_latDone = r_latActive & (r_latCnt == LAT_LAST);
    end

    // Read strobe and address: raised by go, dropped on accept or give-up
    always_ff @(posedge clock) begin
        if (reset) begin
            r_active <= 1'b0;
            r_addr   <= '0;
        end else if (i_go) begin
            r_active <= 1'b1;
            r_addr   <= i_addr;
        end else if (w_timeout || w_accept) begin
            r_active <= 1'b0;
        end
    end

    // Consecutive-stall counter, restarted by every new transaction, saturating
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (i_go) begin
            r_stallCnt <= '0;
        end else if (w_stalled && (r_stallCnt != STALL_LIMIT)) begin
            r_stallCnt <= r_stallCnt + STALL_ONE;
        end
    end

    // Fixed-latency wait after acceptance; data is flagged on its last cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_latActive <= 1'b0;
            r_latCnt    <= '0;
        end else if (i_go) begin
            r_latActive <= 1'b0;
            r_latCnt    <= '0;
        end else if (HAS_LAT && w_accept) begin
            r_latActive <= 1'b1;
            r_latCnt    <= '0;
        end else if (r_latActive) begin
            if (w_latDone) begin
                r_latActive <= 1'b0;
            end else begin
                r_latCnt <= r_latCnt + LAT_ONE;
            end
        end
    end

    // Drive the bus and report completion; data is valid only with o_rdDone
    always_comb begin
        o_address   = r_addr;
        o_read      = r_active;
        o_rdAccept  = w_accept;
        o_rdDone    = HAS_LAT ? w_latDone : w_accept;
        o_rdData    = i_readData;
        o_rdTimeout = w_timeout;
    end

endmodule

// File: rtl/sysid_probe.sv
// System-ID probe: on a start pulse reads the ID word and then the
// timestamp word from the sysid slave, compares the ID with the build's
// expected value and reports match/timeout plus the captured words to
// the boot and health logic.
module sysid_probe
    import sysid_pkg::*;
#(
    parameter int          ADDR_W       = 1,
    parameter int          ID_ADDR      = DEFAULT_ID_ADDR,
    parameter int          TS_ADDR      = DEFAULT_TS_ADDR,
    parameter logic [31:0] EXPECTED_ID  = DEFAULT_EXPECTED_ID,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT_CYC  = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              id_match,
    output logic              timeout,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value
);

    localparam logic [ADDR_W-1:0] ID_A = ADDR_W'(ID_ADDR);
    localparam logic [ADDR_W-1:0] TS_A = ADDR_W'(TS_ADDR);

    probe_state_t r_state;
    probe_state_t w_nextState;

    logic              w_go;
    logic [ADDR_W-1:0] w_goAddr;
    logic              w_startOk;
    logic              w_enterFin;

    logic              w_rdAccept;
    logic              w_rdDone;
    logic [31:0]       w_rdData;
    logic              w_rdTimeout;

    logic [31:0]       r_idValue;
    logic [31:0]       r_tsValue;
    logic              r_timeout;
    logic              r_idMatch;

    avm_single_read #(
        .ADDR_W       (ADDR_W),
        .READ_LATENCY (READ_LATENCY),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) u_reader (
        .clock         (clock),
        .reset         (reset),
        .i_go          (w_go),
        .i_addr        (w_goAddr),
        .i_waitRequest (avm_waitrequest),
        .i_readData    (avm_readdata),
        .o_address     (avm_address),
        .o_read        (avm_read),
        .o_rdAccept    (w_rdAccept),
        .o_rdDone      (w_rdDone),
        .o_rdData      (w_rdData),
        .o_rdTimeout   (w_rdTimeout)
    );

    // Sequencer state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and read launches; the go pulse fires on the edge that enters a read state
    always_comb begin
        w_nextState = r_state;
        w_go        = 1'b0;
        w_goAddr    = ID_A;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_RD_ID;
                    w_go        = 1'b1;
                    w_goAddr    = ID_A;
                end
            end
            S_RD_ID: begin
                if (w_rdTimeout) begin
                    w_nextState = S_FIN;
                end else if (w_rdDone) begin
                    w_nextState = S_RD_TS;
                    w_go        = 1'b1;
                    w_goAddr    = TS_A;
                end else if (w_rdAccept) begin
                    w_nextState = S_LAT_ID;
                end
            end
            S_LAT_ID: begin
                if (w_rdDone) begin
                    w_nextState = S_RD_TS;
                    w_go        = 1'b1;
                    w_goAddr    = TS_A;
                end
            end
            S_RD_TS: begin
                if (w_rdTimeout || w_rdDone) begin
                    w_nextState = S_FIN;
                end else if (w_rdAccept) begin
                    w_nextState = S_LAT_TS;
                end
            end
            S_LAT_TS: begin
                if (w_rdDone) begin
                    w_nextState = S_FIN;
                end
            end
            S_FIN: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Decode a few shared qualifiers used by the result registers
    always_comb begin
        w_startOk  = (r_state == S_IDLE) && start;
        w_enterFin = (w_nextState == S_FIN) && (r_state != S_FIN);
    end

    // Captured words: cleared on an accepted start, loaded when each read completes
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idValue <= '0;
            r_tsValue <= '0;
        end else if (w_startOk) begin
            r_idValue <= '0;
            r_tsValue <= '0;
        end else if (w_rdDone) begin
            if (isIdPhase(r_state)) begin
                r_idValue <= w_rdData;
            end
            if (isTsPhase(r_state)) begin
                r_tsValue <= w_rdData;
            end
        end
    end

    // Verdict flags: timeout latches on a give-up, match is judged on the way into FIN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout <= 1'b0;
            r_idMatch <= 1'b0;
        end else if (w_startOk) begin
            r_timeout <= 1'b0;
            r_idMatch <= 1'b0;
        end else begin
            if (w_rdTimeout) begin
                r_timeout <= 1'b1;
            end
            if (w_enterFin) begin
                r_idMatch <= ~w_rdTimeout && (r_idValue == EXPECTED_ID);
            end
        end
    end

    // Status and result outputs
    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_FIN);
        id_match = r_idMatch;
        timeout  = r_timeout;
        id_value = r_idValue;
        ts_value = r_tsValue;
    end

endmodule

// File: tb/tb_sysid_probe.sv
// Bench for sysid_probe: two instances (zero latency / long timeout and
// latency 2 / short timeout) each talking to a behavioural sysid slave.
// Expected results come from a per-probe model built from the probe rules.
module tb_sysid_probe;

    localparam logic [31:0] EXP_ID = 32'h1234_ABCD;
    localparam int LAT0 = 0;
    localparam int TO0  = 255;
    localparam int LAT1 = 2;
    localparam int TO1  = 4;

    typedef struct {
        bit          to;
        logic [31:0] idv;
        logic [31:0] tsv;
        bit          match;
        int          busyCycles;
        int          readCycles;
        int          nAccepted;
    } expect_t;

    logic        clock;
    logic        reset;
    logic        start    [2];
    logic        wreq     [2];
    logic [31:0] rdata    [2];
    logic [0:0]  avmAddr  [2];
    logic        avmRead  [2];
    logic        busy     [2];
    logic        done     [2];
    logic        idMatch  [2];
    logic        timeoutO [2];
    logic [31:0] idValue  [2];
    logic [31:0] tsValue  [2];

    // slave configuration, written only by the test process
    logic [31:0] cfgId    [2];
    logic [31:0] cfgTs    [2];
    int          cfgStall [2][2];
    bit          cfgStuck [2][2];

    // slave statistics, written only by the slave process
    int rdCycles     [2];
    int accN         [2];
    int accLog       [2][64];
    int addrUnstable [2];

    int nChecks = 0;
    int nPass   = 0;

    sysid_probe #(
        .ADDR_W(1), .ID_ADDR(0), .TS_ADDR(1), .EXPECTED_ID(EXP_ID),
        .READ_LATENCY(LAT0), .TIMEOUT_CYC(TO0)
    ) u_dut0 (
        .clock(clock), .reset(reset), .start(start[0]),
        .avm_address(avmAddr[0]), .avm_read(avmRead[0]),
        .avm_waitrequest(wreq[0]), .avm_readdata(rdata[0]),
        .busy(busy[0]), .done(done[0]), .id_match(idMatch[0]),
        .timeout(timeoutO[0]), .id_value(idValue[0]), .ts_value(tsValue[0])
    );

    sysid_probe #(
        .ADDR_W(1), .ID_ADDR(0), .TS_ADDR(1), .EXPECTED_ID(EXP_ID),
        .READ_LATENCY(LAT1), .TIMEOUT_CYC(TO1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .start(start[1]),
        .avm_address(avmAddr[1]), .avm_read(avmRead[1]),
        .avm_waitrequest(wreq[1]), .avm_readdata(rdata[1]),
        .busy(busy[1]), .done(done[1]), .id_match(idMatch[1]),
        .timeout(timeoutO[1]), .id_value(idValue[1]), .ts_value(tsValue[1])
    );

    // free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // hard stop in case something hangs outside the bounded loops
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int latOf(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int toOf(input int d);
        return (d == 0) ? TO0 : TO1;
    endfunction

    // Outcome of one probe derived from the read rules: each read costs its
    // stall cycles plus one accept cycle plus the latency, or exactly the
    // timeout budget when it stalls too long; FIN adds one busy cycle.
    function automatic expect_t model(input int d, input logic [31:0] idw,
                                      input logic [31:0] tsw, input int sid,
                                      input int sts, input bit kid, input bit kts);
        expect_t e;
        int to = toOf(d);
        int lat = latOf(d);
        e.to = 0; e.idv = 32'h0; e.tsv = 32'h0; e.match = 0;
        e.busyCycles = 1; e.readCycles = 0; e.nAccepted = 0;
        if (kid || sid >= to) begin
            e.to = 1;
            e.busyCycles += to;
            e.readCycles += to;
        end else begin
            e.idv = idw;
            e.busyCycles += sid + 1 + lat;
            e.readCycles += sid + 1;
            e.nAccepted = 1;
            if (kts || sts >= to) begin
                e.to = 1;
                e.busyCycles += to;
                e.readCycles += to;
            end else begin
                e.tsv = tsw;
                e.busyCycles += sts + 1 + lat;
                e.readCycles += sts + 1;
                e.nAccepted = 2;
            end
        end
        e.match = !e.to && (idw == EXP_ID);
        return e;
    endfunction

    // Behavioural sysid slave for both instances, acting mid-cycle
    initial begin
        int rem [2];
        logic [31:0] held [2];
        int stalls [2];
        int sAddr [2];
        int a;
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; held[d] = 32'h0; stalls[d] = 0; sAddr[d] = -1;
            rdCycles[d] = 0; accN[d] = 0; addrUnstable[d] = 0;
            wreq[d] = 1'b0; rdata[d] = 32'h0;
        end
        forever begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                wreq[d]  = 1'b0;
                rdata[d] = $urandom();
                if (reset) begin
                    rem[d] = 0; stalls[d] = 0; sAddr[d] = -1;
                end else begin
                    if (rem[d] > 0) begin
                        rem[d]--;
                        if (rem[d] == 0) rdata[d] = held[d];
                    end
                    if (avmRead[d] === 1'b1) begin
                        a = int'(avmAddr[d]);
                        rdCycles[d]++;
                        if (sAddr[d] >= 0 && sAddr[d] != a) addrUnstable[d]++;
                        if (cfgStuck[d][a] || stalls[d] < cfgStall[d][a]) begin
                            wreq[d] = 1'b1;
                            stalls[d]++;
                            sAddr[d] = a;
                        end else begin
                            stalls[d] = 0;
                            sAddr[d] = -1;
                            accLog[d][accN[d] % 64] = a;
                            accN[d]++;
                            if (latOf(d) == 0) begin
                                rdata[d] = (a == 0) ? cfgId[d] : cfgTs[d];
                            end else begin
                                rem[d]  = latOf(d);
                                held[d] = (a == 0) ? cfgId[d] : cfgTs[d];
                            end
                        end
                    end else begin
                        stalls[d] = 0;
                        sAddr[d] = -1;
                    end
                end
            end
        end
    end

    // Run one probe end to end and compare everything observable with the model
    task automatic run_probe(input int d, input logic [31:0] idw, input logic [31:0] tsw,
                             input int sid, input int sts, input bit kid, input bit kts,
                             input bit hammer, input string tag);
        expect_t e;
        int baseAcc, baseRdc, baseUns;
        int busyCnt, doneCnt, doneAt;
        bit ended;
        logic [31:0] gotId, gotTs;
        logic gotTo, gotMatch;
        e = model(d, idw, tsw, sid, sts, kid, kts);
        cfgId[d] = idw; cfgTs[d] = tsw;
        cfgStall[d][0] = sid; cfgStall[d][1] = sts;
        cfgStuck[d][0] = kid; cfgStuck[d][1] = kts;
        baseAcc = accN[d]; baseRdc = rdCycles[d]; baseUns = addrUnstable[d];
        busyCnt = 0; doneCnt = 0; doneAt = -1; ended = 0;
        gotId = 32'hx; gotTs = 32'hx; gotTo = 1'bx; gotMatch = 1'bx;
        @(negedge clock);
        start[d] = 1'b1;
        @(negedge clock);
        start[d] = hammer;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (busy[d] !== 1'b1) begin
                ended = 1;
                start[d] = 1'b0;
                break;
            end
            busyCnt++;
            if (done[d] === 1'b1) begin
                doneCnt++;
                doneAt = busyCnt;
                gotId = idValue[d]; gotTs = tsValue[d];
                gotTo = timeoutO[d]; gotMatch = idMatch[d];
            end
            @(negedge clock);
        end
        start[d] = 1'b0;
        nChecks++;
        if (!ended) $display("[TB] FAIL %s probe_bound: busy never dropped within 300 cycles", tag);
        else nPass++;
        nChecks++;
        if (doneCnt !== 1) $display("[TB] FAIL %s done_pulses got=%0d want=1", tag, doneCnt);
        else nPass++;
        nChecks++;
        if (busyCnt !== e.busyCycles) $display("[TB] FAIL %s busy_cycles got=%0d want=%0d", tag, busyCnt, e.busyCycles);
        else nPass++;
        nChecks++;
        if (doneAt !== e.busyCycles) $display("[TB] FAIL %s done_position got=%0d want=%0d", tag, doneAt, e.busyCycles);
        else nPass++;
        nChecks++;
        if (gotTo !== e.to) $display("[TB] FAIL %s timeout got=%0b want=%0b", tag, gotTo, e.to);
        else nPass++;
        nChecks++;
        if (gotMatch !== e.match) $display("[TB] FAIL %s id_match got=%0b want=%0b", tag, gotMatch, e.match);
        else nPass++;
        nChecks++;
        if (gotId !== e.idv) $display("[TB] FAIL %s id_value got=%h want=%h", tag, gotId, e.idv);
        else nPass++;
        nChecks++;
        if (gotTs !== e.tsv) $display("[TB] FAIL %s ts_value got=%h want=%h", tag, gotTs, e.tsv);
        else nPass++;
        nChecks++;
        if (rdCycles[d] - baseRdc !== e.readCycles)
            $display("[TB] FAIL %s read_strobe_cycles got=%0d want=%0d", tag, rdCycles[d] - baseRdc, e.readCycles);
        else nPass++;
        nChecks++;
        if (accN[d] - baseAcc !== e.nAccepted)
            $display("[TB] FAIL %s accepted_reads got=%0d want=%0d", tag, accN[d] - baseAcc, e.nAccepted);
        else nPass++;
        for (int k = 0; k < e.nAccepted; k++) begin
            nChecks++;
            if (accLog[d][(baseAcc + k) % 64] !== k)
                $display("[TB] FAIL %s read_addr[%0d] got=%0d want=%0d", tag, k, accLog[d][(baseAcc + k) % 64], k);
            else nPass++;
        end
        nChecks++;
        if (addrUnstable[d] - baseUns !== 0)
            $display("[TB] FAIL %s addr_stable_in_stall got=%0d changes want=0", tag, addrUnstable[d] - baseUns);
        else nPass++;
        repeat (2) @(negedge clock);
        nChecks++;
        if (busy[d] !== 1'b0 || avmRead[d] !== 1'b0)
            $display("[TB] FAIL %s idle_after busy=%0b read=%0b want 0/0", tag, busy[d], avmRead[d]);
        else nPass++;
        nChecks++;
        if (idValue[d] !== e.idv || tsValue[d] !== e.tsv || timeoutO[d] !== e.to || idMatch[d] !== e.match)
            $display("[TB] FAIL %s results_hold id=%h ts=%h to=%0b m=%0b want %h %h %0b %0b", tag,
                     idValue[d], tsValue[d], timeoutO[d], idMatch[d], e.idv, e.tsv, e.to, e.match);
        else nPass++;
    endtask

    // every output of an instance must read zero
    task automatic check_all_zero(input int d, input string tag);
        nChecks++;
        if (avmRead[d] !== 1'b0 || avmAddr[d] !== 1'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0 ||
            idMatch[d] !== 1'b0 || timeoutO[d] !== 1'b0 || idValue[d] !== 32'h0 || tsValue[d] !== 32'h0)
            $display("[TB] FAIL %s outputs_zero rd=%0b a=%0b busy=%0b done=%0b m=%0b to=%0b id=%h ts=%h want all 0",
                     tag, avmRead[d], avmAddr[d], busy[d], done[d], idMatch[d], timeoutO[d], idValue[d], tsValue[d]);
        else nPass++;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) check_all_zero(d, "reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) check_all_zero(d, "reset_release");
    endtask

    task automatic test_match();
        run_probe(0, EXP_ID, 32'h5A5A_0001, 0, 0, 0, 0, 0, "match_lat0");
    endtask

    task automatic test_mismatch();
        run_probe(0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 0, 0, 0, "mismatch_lat0");
    endtask

    task automatic test_latency_stall();
        run_probe(1, EXP_ID, 32'h5A5A_0002, 3, 3, 0, 0, 0, "lat2_stall3");
    endtask

    task automatic test_timeout();
        run_probe(1, EXP_ID, 32'h7777_0001, 1, 0, 0, 1, 0, "timeout_ts");
        run_probe(1, EXP_ID, 32'h7777_0002, 0, 0, 1, 0, 0, "timeout_id");
        run_probe(1, EXP_ID, 32'h7777_0003, 3, 4, 0, 0, 0, "timeout_ts_exact");
    endtask

    // reset in the ID latency phase and again in the TS latency phase
    task automatic test_reset_mid_probe();
        int waitCycles;
        for (int ph = 0; ph < 2; ph++) begin
            cfgId[1] = 32'hCAFE_0000 | ph; cfgTs[1] = 32'h0;
            cfgStall[1][0] = 0; cfgStall[1][1] = 0;
            cfgStuck[1][0] = 0; cfgStuck[1][1] = 0;
            waitCycles = (ph == 0) ? 1 : 4;
            @(negedge clock);
            start[1] = 1'b1;
            @(negedge clock);
            start[1] = 1'b0;
            repeat (waitCycles) @(negedge clock);
            nChecks++;
            if (busy[1] !== 1'b1 || avmRead[1] !== 1'b0)
                $display("[TB] FAIL rst_mid%0d in_latency busy=%0b read=%0b want 1/0", ph, busy[1], avmRead[1]);
            else nPass++;
            if (ph == 1) begin
                nChecks++;
                if (idValue[1] !== cfgId[1])
                    $display("[TB] FAIL rst_mid1 id_before_reset got=%h want=%h", idValue[1], cfgId[1]);
                else nPass++;
            end
            reset = 1'b1;
            @(negedge clock);
            check_all_zero(1, "rst_mid_next");
            reset = 1'b0;
            for (int k = 0; k < 5; k++) begin
                @(negedge clock);
                nChecks++;
                if (done[1] !== 1'b0 || busy[1] !== 1'b0)
                    $display("[TB] FAIL rst_mid%0d no_done_after cyc=%0d done=%0b busy=%0b want 0/0", ph, k, done[1], busy[1]);
                else nPass++;
            end
        end
    endtask

    task automatic test_ignore_start();
        run_probe(0, EXP_ID, 32'h0000_1111, 2, 1, 0, 0, 1, "hammer_lat0");
        run_probe(1, 32'h0F0F_0F0F, 32'h0000_2222, 1, 2, 0, 0, 1, "hammer_lat2");
    endtask

    task automatic test_back_to_back();
        run_probe(1, EXP_ID, 32'hB2B0_0001, 0, 0, 0, 0, 0, "b2b_first");
        run_probe(1, 32'hB2B0_FFFF, 32'hB2B0_0002, 0, 1, 0, 0, 0, "b2b_second");
        run_probe(1, EXP_ID, 32'hB2B0_0003, 0, 0, 0, 0, 0, "b2b_third");
    endtask

    task automatic test_random();
        int d;
        logic [31:0] idw;
        for (int n = 0; n < 24; n++) begin
            d = $urandom_range(0, 1);
            idw = ($urandom_range(0, 2) == 0) ? EXP_ID : $urandom();
            run_probe(d, idw, $urandom(), $urandom_range(0, 5), $urandom_range(0, 5),
                      ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                      $urandom_range(0, 1) == 1, $sformatf("rand%0d_d%0d", n, d));
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            cfgId[d] = 32'h0; cfgTs[d] = 32'h0;
            cfgStall[d][0] = 0; cfgStall[d][1] = 0;
            cfgStuck[d][0] = 0; cfgStuck[d][1] = 0;
        end
        repeat (3) @(negedge clock);
        test_reset();
        test_match();
        test_mismatch();
        test_latency_stall();
        test_timeout();
        test_reset_mid_probe();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
